isqrt_pipe: RTL
===============

// Module: isqrt_pipe
// PURPOSE
//  Integer square root responder: y = floor(sqrt(x)) for unsigned N-bit x.
//  Serves the isqrt_*_x/_y request/response interface driven by the formula FSMs.
//  Fully pipelined digit-by-digit (restoring) algorithm with fixed latency.
//  Accepts one request per cycle; requesters count on constant latency and in-order results.
// PARAMETERS
//  N               32  input width; must be even, >= 4; output width is N/2
//  ITER_PER_STAGE  1   root bits resolved per pipeline stage; must divide N/2
// PORTS
//  clk    in   1    clock
//  rst    in   1    synchronous reset, active-high
//  x_vld  in   1    request valid; x is sampled on each clk edge where x_vld=1
//  x      in   N    radicand, unsigned
//  y_vld  out  1    response valid, exactly one cycle per accepted request
//  y      out  N/2  floor(sqrt(x)); don't-care while y_vld=0
// BEHAVIOUR
//  - Reset is rst, synchronous, active-high; clock is clk.
//  - Latency: LAT = (N/2)/ITER_PER_STAGE cycles (16 with defaults). x_vld=1 sampled
//    at edge k -> y_vld=1 during the cycle following edge k+LAT-1; no input skid, no backpressure.
//  - Throughput 1/cycle. No ready signal: every x_vld=1 cycle is accepted.
//  - Ordering: responses leave in request order, one per request, no merging/dropping.
//  - Per-stage state: valid bit, remaining radicand bits, partial remainder (N/2+2 bits),
//    partial root (N/2 bits). Only valid bits reset (to 0); data regs not reset, no enables
//    required (data may advance every cycle).
//  - Iteration i (MSB pair first): rem = (rem<<2) | next 2 bits of x; trial = (root<<2)|1;
//    rem >= trial -> rem -= trial, root = (root<<1)|1; else root = root<<1.
//    All compares unsigned, rem width N/2+2 bits, no overflow possible.
//  - Stage 0 starts rem=0, root=0. y = root of last stage, registered output.
//  - Reset values: y_vld=0; y unspecified (bench ignores while y_vld=0).
//  - Reset mid-operation: all valid bits clear at the rst edge; in-flight requests are
//    discarded, never produce y_vld. x_vld during rst is ignored.
//    First request after rst deasserted obeys LAT exactly.
//  - Idle gaps: x_vld=0 cycles propagate as bubbles; y_vld=0 in matching cycles.
//  - Boundaries: x=0 -> 0; x=2^N-1 -> 2^(N/2)-1; perfect squares exact, k^2-1 -> k-1.
//  - Elaboration check: $error if N odd or (N/2)%ITER_PER_STAGE != 0.
// STRUCTURE
//  - isqrt_pkg: ISQRT_N default (32), function isqrt_latency(n, ips) returning
//    (n/2)/ips, shared with the formula FSMs and testbenches for latency checks.
//  - Sub-module isqrt_step: purely combinational single iteration
//    (rem_in, root_in, two_bits -> rem_out, root_out), parameterised by N;
//    isqrt_pipe instantiates ITER_PER_STAGE copies per stage in a generate loop
//    and registers between stages.
//  - Valid bits form a LAT-deep shift register parallel to the data path.
// TESTING
//  - Single requests x=0,1,15,16 -> y=0,1,3,4, y_vld exactly LAT=16 cycles after accept.
//  - x=32'hFFFF_FFFF -> y=16'hFFFF; x=32'hFFFE_0001 -> y=16'hFFFF; x=32'hFFFE_0000 -> 16'hFFFE.
//  - Back-to-back x=100,144,2,1_000_000 on 4 consecutive cycles -> y=10,12,1,1000 on
//    4 consecutive cycles, in order, starting LAT cycles after the first.
//  - Sparse stream with random gaps: y_vld pattern equals x_vld pattern delayed by LAT;
//    10k random x checked against reference model floor(sqrt(x)).
//  - Issue x=49 at t, assert rst at t+5 for 1 cycle -> no y_vld ever for 49;
//    x=81 right after rst -> y=9 after exactly LAT cycles.
//  - Re-run random test with ITER_PER_STAGE=2,4 (LAT=8,4) -> same values, new latency.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared definitions for the integer square root responder.
//   ISQRT_N        default radicand width
//   isqrt_latency  pipeline latency in cycles for a given width and
//                  number of root bits resolved per stage
package isqrt_pkg;

  localparam int ISQRT_N = 32;

  function automatic int isqrt_latency(input int n, input int ips);
    return (n / 2) / ips;
  endfunction

endpackage

// File: rtl/isqrt_if.sv
// Request/response bundle between the formula FSMs and isqrt_pipe.
//   x_vld  request valid (no ready: every valid cycle is accepted)
//   x      radicand, unsigned, N bits
//   y_vld  response valid, one cycle per accepted request
//   y      floor(sqrt(x)), N/2 bits
// master = requester, slave = isqrt_pipe.
interface isqrt_if #(
  parameter int N = isqrt_pkg::ISQRT_N
) ();

  logic           x_vld;
  logic [N-1:0]   x;
  logic           y_vld;
  logic [N/2-1:0] y;

  modport master (output x_vld, output x, input  y_vld, input  y);
  modport slave  (input  x_vld, input  x, output y_vld, output y);

endinterface

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square root iteration (combinational).
//   i_rem       partial remainder in  (N/2+2 bits)
//   i_root      partial root in       (N/2 bits)
//   i_two_bits  next radicand bit pair, MSB pair first
//   o_rem       partial remainder out
//   o_root      partial root out, one more root bit resolved
module isqrt_step #(
  parameter int N = 32
) (
  input  logic [N/2+1:0] i_rem,
  input  logic [N/2-1:0] i_root,
  input  logic [1:0]     i_two_bits,
  output logic [N/2+1:0] o_rem,
  output logic [N/2-1:0] o_root
);

  localparam int H  = N / 2;
  localparam int RW = H + 2;

  logic [RW-1:0] w_rem_sh;
  logic [RW-1:0] w_trial;
  logic          w_ge;

  // The bits shifted out of the remainder are always zero: after i resolved
  // root bits rem <= 2*root < 2^(i+1), so (rem<<2) still fits in RW bits.
  assign w_rem_sh = (i_rem << 2) | {{(RW-2){1'b0}}, i_two_bits};
  assign w_trial  = {i_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);

  assign o_rem  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign o_root = {i_root[H-2:0], w_ge};

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined integer square root: y = floor(sqrt(x)), fixed latency
// isqrt_latency(N, ITER_PER_STAGE), one request per cycle, in-order results.
//   clk  clock
//   rst  synchronous active-high reset; clears only the valid pipeline
//   bus  isqrt_if slave: x_vld/x in, y_vld/y out (y is a registered output)
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int N              = ISQRT_N,
  parameter int ITER_PER_STAGE = 1
) (
  input  logic   clk,
  input  logic   rst,
  isqrt_if.slave bus
);

  localparam int H   = N / 2;
  localparam int RW  = H + 2;
  localparam int LAT = isqrt_latency(N, ITER_PER_STAGE);

  if ((N % 2) != 0 || N < 4 || (H % ITER_PER_STAGE) != 0) begin : g_bad_param
    $error("isqrt_pipe: N must be even and >= 4, and ITER_PER_STAGE must divide N/2");
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    logic          r_vld;
    logic [N-1:0]  r_rad;
    logic [RW-1:0] r_rem;
    logic [H-1:0]  r_root;

    logic          w_vld_in;
    logic [N-1:0]  w_rad_in;
    logic [RW-1:0] w_rem_c  [ITER_PER_STAGE+1];
    logic [H-1:0]  w_root_c [ITER_PER_STAGE+1];

    // Stage boundary: stage 0 takes the request, later stages the previous register
    if (s == 0) begin : g_head
      assign w_vld_in    = bus.x_vld;
      assign w_rad_in    = bus.x;
      assign w_rem_c[0]  = '0;
      assign w_root_c[0] = '0;
    end else begin : g_link
      assign w_vld_in    = g_stage[s-1].r_vld;
      assign w_rad_in    = g_stage[s-1].r_rad;
      assign w_rem_c[0]  = g_stage[s-1].r_rem;
      assign w_root_c[0] = g_stage[s-1].r_root;
    end

    // Unconsumed radicand bits stay MSB-aligned so every stage reads the top pairs
    for (genvar k = 0; k < ITER_PER_STAGE; k++) begin : g_iter
      isqrt_step #(.N(N)) u_step (
        .i_rem      (w_rem_c[k]),
        .i_root     (w_root_c[k]),
        .i_two_bits (w_rad_in[N-1-2*k -: 2]),
        .o_rem      (w_rem_c[k+1]),
        .o_root     (w_root_c[k+1])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) r_vld <= 1'b0;
      else     r_vld <= w_vld_in;
    end

    always_ff @(posedge clk) begin
      r_rad  <= w_rad_in << (2 * ITER_PER_STAGE);
      r_rem  <= w_rem_c[ITER_PER_STAGE];
      r_root <= w_root_c[ITER_PER_STAGE];
    end
  end

  // The final remainder and the exhausted radicand have no consumer.
  logic w_unused_tail;
  assign w_unused_tail = ^{g_stage[LAT-1].r_rad, g_stage[LAT-1].r_rem};

  // Output boundary: last stage register drives the response
  assign bus.y_vld = g_stage[LAT-1].r_vld;
  assign bus.y     = g_stage[LAT-1].r_root;

endmodule
